// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared widths, requester-index type and sizing helper for the
// framebuffer read arbiter.
package fb_arb_pkg;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int MAX_REQ = 8;
    typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fb_arb_tag_fifo.sv
// fb_arb_tag_fifo: in-order tag FIFO recording which requester owns each
// outstanding downstream read.
module fb_arb_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push, do_pop;
    assign full_o  = cnt_q == (PTR_W+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + PTR_W'(do_push);
            rd_q  <= rd_q + PTR_W'(do_pop);
            cnt_q <= cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/fb_read_arbiter.sv
// fb_read_arbiter: round-robin arbiter merging several Avalon-MM read
// requesters onto one pipelined master, routing in-order responses back.
module fb_read_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MAX_PENDING = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             avs_req_read,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] avs_req_address,
    output logic [NUM_REQ-1:0]             avs_req_waitrequest,
    output logic [DATA_W-1:0]              avs_req_readdata,
    output logic [NUM_REQ-1:0]             avs_req_readdatavalid,
    output logic                           avm_master_read,
    output logic [ADDR_W-1:0]              avm_master_address,
    input  logic                           avm_master_waitrequest,
    input  logic [DATA_W-1:0]              avm_master_readdata,
    input  logic                           avm_master_readdatavalid,
    output logic                           err_unexpected
);
    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_PENDING) + 1;
    logic [IDX_W-1:0]   last_q, last_d, gnt_idx, rr_idx;
    logic               gnt_any, slot_free, grant, pop;
    logic               armed_q;
    logic               read_q, read_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [NUM_REQ-1:0] rdv_q, rdv_d, gnt_oh;
    logic               err_q, err_d;
    logic               fifo_full, fifo_empty;
    req_idx_t           head;
    logic [CNT_W-1:0]   count;
    // Scan offsets from farthest to nearest so the requester right after the
    // last grant is the one left standing.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_idx  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            rr_idx = IDX_W'((int'(last_q) + i) % NUM_REQ);
            if (avs_req_read[rr_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx;
            end
        end
    end
    assign slot_free           = !read_q || !avm_master_waitrequest;
    assign grant               = armed_q && gnt_any && slot_free && !fifo_full;
    assign gnt_oh              = grant ? NUM_REQ'(1) << gnt_idx : '0;
    assign avs_req_waitrequest = avs_req_read & ~gnt_oh;
    assign pop                 = avm_master_readdatavalid && count != '0;
    always_comb begin
        read_d  = grant || (read_q && !slot_free);
        addr_d  = grant ? avs_req_address[gnt_idx] : addr_q;
        last_d  = grant ? gnt_idx : last_q;
        rdata_d = pop ? avm_master_readdata : rdata_q;
        rdv_d   = pop ? NUM_REQ'(1) << head : '0;
        err_d   = err_q || (avm_master_readdatavalid && fifo_empty);
    end
    // armed_q keeps the first edge after reset release grant-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q <= 1'b0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            read_q  <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
            rdv_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            last_q  <= last_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            rdv_q   <= rdv_d;
            err_q   <= err_d;
        end
    end
    fb_arb_tag_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH ($bits(req_idx_t))
    ) u_tags (
        .clk     (clk),
        .rst     (reset),
        .push_i  (grant),
        .pop_i   (pop),
        .din_i   (req_idx_t'(gnt_idx)),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );
    assign avm_master_read       = read_q;
    assign avm_master_address    = addr_q;
    assign avs_req_readdata      = rdata_q;
    assign avs_req_readdatavalid = rdv_q;
    assign err_unexpected        = err_q;
endmodule

// File: tb/tb_fb_read_arbiter.sv
// tb_fb_read_arbiter: randomized bench with an in-order slave model, a
// transaction-level arbiter model and a response scoreboard.
module tb_fb_read_arbiter;
    import fb_arb_pkg::*;
    localparam int N  = 2;
    localparam int MP = 8;
    logic                     clk = 1'b0;
    logic                     reset;
    logic [N-1:0]             rd, wreq, rdv;
    logic [N-1:0][ADDR_W-1:0] addr;
    logic [DATA_W-1:0]        rdata, m_rdata;
    logic                     m_read, m_wait, m_rdv, err;
    logic [ADDR_W-1:0]        m_addr;
    always #5 clk = ~clk;
    fb_read_arbiter #(.NUM_REQ(N), .MAX_PENDING(MP)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .avs_req_read             (rd),
        .avs_req_address          (addr),
        .avs_req_waitrequest      (wreq),
        .avs_req_readdata         (rdata),
        .avs_req_readdatavalid    (rdv),
        .avm_master_read          (m_read),
        .avm_master_address       (m_addr),
        .avm_master_waitrequest   (m_wait),
        .avm_master_readdata      (m_rdata),
        .avm_master_readdatavalid (m_rdv),
        .err_unexpected           (err)
    );
    typedef struct packed {
        logic [N-1:0]      oh;
        logic [DATA_W-1:0] d;
    } rsp_t;
    int tests = 0, fails = 0;
    rsp_t              sb[$];
    int                tag_q[$];
    logic [ADDR_W-1:0] slave_q[$];
    int                last, pend;
    bit                busy, armed, merr;
    logic [ADDR_W-1:0] maddr;
    rsp_t              mon_r;
    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5a3c;
    endfunction
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    task automatic model_reset();
        pend = 0; busy = 0; armed = 0; merr = 0; last = N - 1; maddr = '0;
        tag_q.delete(); slave_q.delete(); sb.delete();
    endtask
    task automatic check_reset_outputs();
        chk("rst_m_read", 32'(m_read), 32'(0));
        chk("rst_m_addr", 32'(m_addr), 32'(0));
        chk("rst_rdv", 32'(rdv), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
    endtask
    // pw/pv/pr: percent chance of slave stall, slave data return, requester read.
    task automatic cycle(input int pw, input int pv, input int pr, input bit spur);
        int g, k;
        bit free;
        logic [ADDR_W-1:0] a;
        rsp_t r;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            rd[i]   = $urandom_range(99) < pr;
            addr[i] = ADDR_W'($urandom);
        end
        m_wait  = $urandom_range(99) < pw;
        m_rdv   = spur || (slave_q.size() > 0 && $urandom_range(99) < pv);
        m_rdata = slave_q.size() > 0 ? data_of(slave_q[0]) : DATA_W'($urandom);
        #1;
        free = !busy || !m_wait;
        g = -1;
        if (armed && free && pend < MP)
            for (int i = 1; i <= N; i++) begin
                k = (last + i) % N;
                if (rd[k] && g < 0) g = k;
            end
        for (int i = 0; i < N; i++)
            if (rd[i]) chk("waitreq", 32'(wreq[i]), 32'(i != g));
        @(posedge clk);
        if (m_rdv) begin
            if (pend > 0) begin
                a = slave_q.pop_front();
                k = tag_q.pop_front();
                r.oh = N'(1) << k;
                r.d  = data_of(a);
                sb.push_back(r);
                pend--;
            end else merr = 1;
        end
        if (busy && !m_wait) slave_q.push_back(maddr);
        if (g >= 0) begin
            pend++;
            tag_q.push_back(g);
            busy = 1;
            maddr = addr[g];
            last = g;
        end else if (free) busy = 0;
        armed = 1;
        #1;
        chk("m_read", 32'(m_read), 32'(busy));
        if (busy) chk("m_addr", 32'(m_addr), 32'(maddr));
        chk("err", 32'(err), 32'(merr));
    endtask
    initial forever begin
        @(negedge clk);
        if (!reset && (rdv != '0 || sb.size() > 0)) begin
            if (sb.size() == 0) chk("rsp_spurious", 32'(rdv), 32'(0));
            else begin
                mon_r = sb.pop_front();
                chk("rsp_valid", 32'(rdv), 32'(mon_r.oh));
                chk("rsp_data", 32'(rdata), 32'(mon_r.d));
            end
        end
    end
    initial begin
        reset = 1; rd = '0; addr = '0; m_wait = 0; m_rdv = 0; m_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #2 reset = 0;
        repeat (400) cycle(20, 40, 70, 0);
        repeat (20) cycle(0, 0, 100, 0);
        repeat (30) cycle(30, 60, 60, 0);
        repeat (10) cycle(0, 0, 100, 0);
        @(posedge clk); #2 reset = 1;
        #1 check_reset_outputs();
        model_reset();
        repeat (2) @(negedge clk);
        @(posedge clk); #2 reset = 0;
        repeat (300) cycle(40, 50, 80, 0);
        repeat (40) cycle(0, 100, 0, 0);
        cycle(0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0);
        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
